// File: rtl/sram_ctrl_pkg.sv
// Shared types and geometry for the RW0 SRAM controller.
// The optional array-zeroing sweep is built when SRAM_CTRL_INIT_EN is defined.
package sram_ctrl_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned LANE_W = 6;
    localparam int unsigned DATA_W = MASK_W * LANE_W;
    localparam int unsigned DEPTH  = 4096;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } ctrl_state_e;

endpackage

// File: rtl/sram_ctrl_resp_fifo.sv
// Read-response FIFO: RESP_DEPTH entries of DATA_W bits, exposing empty and occupancy.
// Push on a full FIFO never happens because the controller's credit count prevents it.
module sram_ctrl_resp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned RESP_DEPTH = 3,
    localparam int unsigned OCC_W = $clog2(RESP_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [DATA_W-1:0] mem [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (occupancy == '0);
    assign do_pop = pop && !empty;
    assign rdata  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves occupancy unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push)   wr_ptr <= bump(wr_ptr);
            if (do_pop) rd_ptr <= bump(rd_ptr);
            case ({push, do_pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage array write.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sram_rw_ctrl.sv
// Initiator-side controller for the 96x4096 single-port RW0 SRAM wrapper.
// Define SRAM_CTRL_INIT_EN to add the post-reset sweep that zeroes the whole array.
module sram_rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned RESP_DEPTH = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_clk,
    output logic              RW0_wmode,
    output logic [DATA_W-1:0] RW0_wdata,
    output logic [MASK_W-1:0] RW0_wmask,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam int unsigned OCC_W = $clog2(RESP_DEPTH + 1);

    ctrl_state_e       state;
    ctrl_state_e       state_next;
    logic              inflight;
    logic              handshake;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W:0]    credit;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

`ifdef SRAM_CTRL_INIT_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    logic [ADDR_W-1:0] sweep_cnt;
`endif

    assign RW0_clk    = clock;
    assign handshake  = req_valid && req_ready;
    assign credit     = (OCC_W + 1)'(occupancy) + (OCC_W + 1)'(inflight);
    assign resp_valid = !fifo_empty;
    assign resp_rdata = resp_valid ? fifo_rdata : '0;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // A read issued this cycle returns data on RW0_rdata next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) inflight <= 1'b0;
        else          inflight <= handshake && !req_write;
    end

`ifdef SRAM_CTRL_INIT_EN
    // Sweep address counter, active only while zeroing the array.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)            sweep_cnt <= '0;
        else if (state == INIT)  sweep_cnt <= sweep_cnt + 1'b1;
        else                     sweep_cnt <= '0;
    end
`endif

    // Next-state logic and RW0 port / handshake outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        init_done  = 1'b0;
        RW0_en     = 1'b0;
        RW0_wmode  = 1'b0;
        RW0_addr   = '0;
        RW0_wdata  = '0;
        RW0_wmask  = '0;
        case (state)
            IDLE: begin
`ifdef SRAM_CTRL_INIT_EN
                state_next = INIT;
`else
                state_next = RUN;
`endif
            end
`ifdef SRAM_CTRL_INIT_EN
            INIT: begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = sweep_cnt;
                RW0_wmask = '1;
                if (sweep_cnt == LAST_ADDR) state_next = RUN;
            end
`endif
            RUN: begin
                init_done = 1'b1;
                req_ready = (credit < (OCC_W + 1)'(RESP_DEPTH));
                if (req_valid && req_ready) begin
                    RW0_en    = 1'b1;
                    RW0_wmode = req_write;
                    RW0_addr  = req_addr;
                    if (req_write) begin
                        RW0_wdata = req_wdata;
                        RW0_wmask = req_wmask;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sram_ctrl_resp_fifo #(
        .RESP_DEPTH(RESP_DEPTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (inflight),
        .pop       (resp_valid && resp_ready),
        .wdata     (RW0_rdata),
        .rdata     (fifo_rdata),
        .empty     (fifo_empty),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Directed self-checking bench for sram_rw_ctrl with a behavioural RW0 SRAM.
// Sweep checks are included when SRAM_CTRL_INIT_EN is defined.
module tb_sram_rw_ctrl;

    localparam logic [95:0] FILL = 96'hA5A5_5A5A_A5A5_5A5A_A5A5_5A5A;
    localparam logic [95:0] WVAL = 96'h0123_4567_89AB_CDEF_0011_2233;
    localparam logic [95:0] PVAL = 96'h0123_4567_89AB_CDEF_0011_223F;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [95:0] req_wdata;
    logic [15:0] req_wmask;
    logic        resp_valid, resp_ready;
    logic [95:0] resp_rdata;
    logic        init_done;
    logic [11:0] RW0_addr;
    logic        RW0_en, RW0_clk, RW0_wmode;
    logic [95:0] RW0_wdata;
    logic [15:0] RW0_wmask;
    logic [95:0] RW0_rdata = '0;

    int checks   = 0;
    int failures = 0;

    logic [95:0] mem [4096];
    bit          written [4096];

    always #5 clock = ~clock;

    sram_rw_ctrl #(.RESP_DEPTH(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_clk(RW0_clk), .RW0_wmode(RW0_wmode),
        .RW0_wdata(RW0_wdata), .RW0_wmask(RW0_wmask), .RW0_rdata(RW0_rdata)
    );

    // Behavioural RW0 macro: masked 6-bit lane writes, registered reads, unwritten words read FILL.
    always @(posedge RW0_clk) begin : sram_model
        logic [95:0] w;
        if (RW0_en) begin
            if (RW0_wmode) begin
                w = written[RW0_addr] ? mem[RW0_addr] : FILL;
                for (int i = 0; i < 16; i++)
                    if (RW0_wmask[i]) w[6*i +: 6] = RW0_wdata[6*i +: 6];
                mem[RW0_addr]     <= w;
                written[RW0_addr] <= 1'b1;
            end else begin
                RW0_rdata <= written[RW0_addr] ? mem[RW0_addr] : FILL;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] pat(input int unsigned i);
        logic [3:0] n;
        n = i[3:0];
        return {24{n}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [95:0] d, input logic [15:0] m);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
        #1;
        check_eq("wr_ready", req_ready, 1'b1);
        check_eq("wr_port", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask}, {1'b1, 1'b1, a, m});
        check_eq("wr_wdata", RW0_wdata, d);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [11:0] a, input logic [95:0] exp);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = '1; req_wmask = '1;
        resp_ready = 1'b0;
        #1;
        check_eq({tag, "_ready"}, req_ready, 1'b1);
        check_eq({tag, "_port"}, {RW0_en, RW0_wmode, RW0_addr, RW0_wmask}, {1'b1, 1'b0, a, 16'h0000});
        check_eq({tag, "_wdata0"}, RW0_wdata, '0);
        tick();
        req_valid = 1'b0;
        #1;
        check_eq({tag, "_t1_valid"}, resp_valid, 1'b0);
        tick();
        check_eq({tag, "_t2_valid"}, resp_valid, 1'b1);
        check_eq({tag, "_data"}, resp_rdata, exp);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        check_eq({tag, "_popped"}, resp_valid, 1'b0);
    endtask

    initial begin
        int hs, issued, got, stalls, first, last, stale, sweep_bad;
        bit reached;
        reset_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h123; req_wdata = '1; req_wmask = '1;
        resp_ready = 1'b1;
        #1;
        check_eq("rst_outputs", {req_ready, resp_valid, init_done, RW0_en, RW0_wmode}, '0);
        check_eq("rst_port", {RW0_addr, RW0_wdata, RW0_wmask}, '0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check_eq("idle_init_done", init_done, 1'b0);
        check_eq("idle_en", RW0_en, 1'b0);

`ifdef SRAM_CTRL_INIT_EN
        sweep_bad = 0;
        for (int n = 1; n <= 4097; n++) begin
            tick();
            if (n <= 4096) begin
                if (!(RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_addr === 12'(n - 1) &&
                      RW0_wdata === '0 && RW0_wmask === 16'hFFFF && init_done === 1'b0 &&
                      req_ready === 1'b0))
                    sweep_bad++;
            end
        end
        check_eq("sweep_ok", sweep_bad, 0);
        check_eq("init_done_4097", init_done, 1'b1);
        req_valid = 1'b0;
        do_read("rd_7ff", 12'h7FF, '0);
`else
        tick();
        check_eq("run_init_done", init_done, 1'b1);
        req_valid = 1'b0;
        #1;
        check_eq("run_ready", req_ready, 1'b1);
`endif

        do_write(12'h010, WVAL, 16'hFFFF);
        do_read("rd_full", 12'h010, WVAL);
        do_write(12'h010, '1, 16'h0001);
        do_read("rd_part", 12'h010, PVAL);

        for (int i = 0; i < 16; i++) do_write(12'(i), pat(i), 16'hFFFF);

        // Backpressure: consumer stalled, reads offered every cycle.
        resp_ready = 1'b0;
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = 12'(hs);
            #1;
            if (req_ready) hs++;
            tick();
        end
        req_valid = 1'b0;
        #1;
        check_eq("bp_handshakes", hs, 3);
        check_eq("bp_ready_low", req_ready, 1'b0);
        resp_ready = 1'b1;
        #1;
        check_eq("bp_resp0", resp_rdata, pat(0));
        check_eq("bp_ready_pop_cycle", req_ready, 1'b0);
        tick();
        check_eq("bp_ready_back", req_ready, 1'b1);
        check_eq("bp_resp1", resp_rdata, pat(1));
        tick();
        check_eq("bp_resp2", resp_rdata, pat(2));
        tick();
        check_eq("bp_drained", resp_valid, 1'b0);

        // Streaming: 16 back-to-back reads with the consumer always ready.
        issued = 0; got = 0; stalls = 0; first = -1; last = -1;
        resp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            req_valid = (issued < 16); req_write = 1'b0; req_addr = 12'(issued);
            #1;
            if (resp_valid) begin
                check_eq("tput_data", resp_rdata, pat(got));
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (req_valid) begin
                if (req_ready) issued++;
                else           stalls++;
            end
            tick();
        end
        req_valid = 1'b0;
        check_eq("tput_issued", issued, 16);
        check_eq("tput_stalls", stalls, 0);
        check_eq("tput_got", got, 16);
        check_eq("tput_first", first, 2);
        check_eq("tput_span", last - first, 15);

        // Reset with one response queued and one read in flight.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'd1;
        tick();
        req_addr = 12'd2;
        tick();
        check_eq("pre_rst_valid", resp_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_fl_outputs", {req_ready, resp_valid, init_done, RW0_en}, '0);
        req_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        stale = 0;
`ifdef SRAM_CTRL_INIT_EN
        tick();
        check_eq("restart_addr0", {RW0_en, RW0_addr}, {1'b1, 12'h000});
`endif
        for (int c = 0; c < 6; c++) begin
            #1;
            if (resp_valid) stale++;
            tick();
        end
        check_eq("no_stale_resp", stale, 0);

`ifdef SRAM_CTRL_INIT_EN
        // Reset in the middle of the sweep.
        reached = 1'b0;
        for (int c = 0; c < 2000 && !reached; c++) begin
            if (RW0_addr == 12'd1000 && RW0_en) reached = 1'b1;
            else tick();
        end
        check_eq("mid_init_reached", reached, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_init_rst_out", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, init_done}, '0);
        tick();
        reset_n = 1'b1;
        tick();
        check_eq("mid_init_restart", {RW0_en, RW0_addr}, {1'b1, 12'h000});
        stale = 0;
        for (int c = 0; c < 5000 && !init_done; c++) begin
            if (resp_valid) stale++;
            tick();
        end
        check_eq("reinit_done", init_done, 1'b1);
        check_eq("reinit_no_stale", stale, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
